// File: rtl/wb_icache.sv
// wb_icache: direct-mapped, read-only instruction cache sitting between a
// Wishbone-style CPU fetch port and a QSPI memory controller.
//
// Handshake (both sides): the requester raises stb with a stable address and
// holds it until the responder returns a one-cycle ack. cpu_ack_o is always
// registered and is high only in RESP. mem_stb_o stays high across all words
// of a line fill, and drops on the edge that samples the final mem_ack_i.
//
// Address map: adr[27]=0 is ROM (cacheable), adr[27]=1 is RAM (bypassed).
// The tag only covers adr[23:...], so ROM aliases above bit 23 share lines.
module wb_icache #(
    parameter int LINES = 4,
    parameter int WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_stb_i,
    input  logic [31:0] cpu_adr_i,
    output logic [31:0] cpu_dat_o,
    output logic        cpu_ack_o,
    input  logic        inv_i,
    output logic        mem_stb_o,
    output logic [31:0] mem_adr_o,
    input  logic [31:0] mem_dat_i,
    input  logic        mem_ack_i,
    output logic [1:0]  dbg_state_o
);

    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TL = 2 + OB + IB;
    localparam int TW = 24 - TL;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_BYPASS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             state_q;
    logic [31:2]        adr_q;
    logic [OB-1:0]      k_q;
    logic [LINES-1:0]   valid_q;
    logic               inv_seen_q;
    logic               cpu_ack_q;
    logic [31:0]        cpu_dat_q;
    logic               mem_stb_q;
    logic [31:0]        mem_adr_q;

    logic [31:0]        data_q [0:LINES*WORDS-1];
    logic [TW-1:0]      tag_q  [0:LINES-1];

    logic [OB-1:0]      req_off;
    logic [IB-1:0]      req_idx;
    logic [TW-1:0]      req_tag;
    logic               req_cache;
    logic               hit;
    logic [31:0]        rd_word;

    logic [OB-1:0]      lat_off;
    logic [IB-1:0]      lat_idx;
    logic [TW-1:0]      lat_tag;
    logic [OB-1:0]      k_nxt;
    logic               last_word;
    logic               fill_we;
    logic               unused_adr;

    // Split the live request address and the latched fill address into fields.
    always_comb begin
        req_off   = cpu_adr_i[2+OB-1:2];
        req_idx   = cpu_adr_i[TL-1:2+OB];
        req_tag   = cpu_adr_i[23:TL];
        req_cache = ~cpu_adr_i[27];
        hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        rd_word   = data_q[{req_idx, req_off}];
        lat_off   = adr_q[2+OB-1:2];
        lat_idx   = adr_q[TL-1:2+OB];
        lat_tag   = adr_q[23:TL];
        k_nxt     = k_q + 1'b1;
        last_word = &k_q;
        fill_we   = (state_q == S_FILL) && mem_ack_i;
    end

    // Byte-offset bits of the fetch address carry no information.
    assign unused_adr = ^cpu_adr_i[1:0];

    // Line storage: written one word per memory ack, tag on the final word.
    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            data_q[{lat_idx, k_q}] <= mem_dat_i;
            if (last_word) begin
                tag_q[lat_idx] <= lat_tag;
            end
        end
    end

    // Control FSM with registered CPU and memory side outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            k_q        <= '0;
            valid_q    <= '0;
            inv_seen_q <= 1'b0;
            cpu_ack_q  <= 1'b0;
            cpu_dat_q  <= '0;
            mem_stb_q  <= 1'b0;
            mem_adr_q  <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            if (inv_i) begin
                valid_q <= '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (cpu_stb_i) begin
                        adr_q <= cpu_adr_i[31:2];
                        if (req_cache && hit) begin
                            cpu_dat_q <= rd_word;
                            cpu_ack_q <= 1'b1;
                            state_q   <= S_RESP;
                        end else if (req_cache) begin
                            // Fills always run word 0 .. WORDS-1.
                            k_q        <= '0;
                            inv_seen_q <= 1'b0;
                            mem_stb_q  <= 1'b1;
                            mem_adr_q  <= {cpu_adr_i[31:2+OB], {OB{1'b0}}, 2'b00};
                            state_q    <= S_FILL;
                        end else begin
                            mem_stb_q <= 1'b1;
                            mem_adr_q <= {cpu_adr_i[31:2], 2'b00};
                            state_q   <= S_BYPASS;
                        end
                    end
                end
                S_FILL: begin
                    if (inv_i) begin
                        inv_seen_q <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        // Capture the requested word as it streams past.
                        if (k_q == lat_off) begin
                            cpu_dat_q <= mem_dat_i;
                        end
                        if (last_word) begin
                            k_q       <= '0;
                            mem_stb_q <= 1'b0;
                            cpu_ack_q <= 1'b1;
                            state_q   <= S_RESP;
                            // An invalidate seen at any point of the fill wins.
                            if (!inv_i && !inv_seen_q) begin
                                valid_q[lat_idx] <= 1'b1;
                            end
                        end else begin
                            k_q       <= k_nxt;
                            mem_adr_q <= {adr_q[31:2+OB], k_nxt, 2'b00};
                        end
                    end
                end
                S_BYPASS: begin
                    if (mem_ack_i) begin
                        cpu_dat_q <= mem_dat_i;
                        mem_stb_q <= 1'b0;
                        cpu_ack_q <= 1'b1;
                        state_q   <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_dat_o   = cpu_dat_q;
    assign cpu_ack_o   = cpu_ack_q;
    assign mem_stb_o   = mem_stb_q;
    assign mem_adr_o   = mem_adr_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_icache.sv
// Directed bench for wb_icache (LINES=4, WORDS=4) with a scripted memory.
module tb_wb_icache;

    localparam int WORDS = 4;

    logic        clk_i;
    logic        rst_i;
    logic        cpu_stb_i;
    logic [31:0] cpu_adr_i;
    logic [31:0] cpu_dat_o;
    logic        cpu_ack_o;
    logic        inv_i;
    logic        mem_stb_o;
    logic [31:0] mem_adr_o;
    logic [31:0] mem_dat_i;
    logic        mem_ack_i;
    logic [1:0]  dbg_state_o;

    int errors;
    int checks;
    logic [31:0] exp_q[$];

    wb_icache #(.LINES(4), .WORDS(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_stb_i   (cpu_stb_i),
        .cpu_adr_i   (cpu_adr_i),
        .cpu_dat_o   (cpu_dat_o),
        .cpu_ack_o   (cpu_ack_o),
        .inv_i       (inv_i),
        .mem_stb_o   (mem_stb_o),
        .mem_adr_o   (mem_adr_o),
        .mem_dat_i   (mem_dat_i),
        .mem_ack_i   (mem_ack_i),
        .dbg_state_o (dbg_state_o)
    );

    // Clock
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Memory contents: line 0x10 holds 0xA0..0xA3, everything else 0xD0000000|addr.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h1) return 32'hA0 + 32'(a[3:2]);
        return 32'hD000_0000 | a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU fetch with a memory responder; inv_at pulses inv_i alongside that mem ack.
    task automatic fetch(input logic [31:0] addr, input int wait_n, input int inv_at,
                         output logic [31:0] dat, output int lat, output int nmem);
        int w;
        int acks;
        logic got;
        @(negedge clk_i);
        cpu_stb_i = 1'b1;
        cpu_adr_i = addr;
        lat = 0; nmem = 0; w = 0; acks = 0; got = 1'b0; dat = '0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk_i);
            lat++;
            mem_ack_i = 1'b0;
            inv_i     = 1'b0;
            if (cpu_ack_o) begin
                got = 1'b1;
                dat = cpu_dat_o;
                check($sformatf("mem_stb_low_at_ack@%h", addr), 32'(mem_stb_o), 32'd0);
            end else if (mem_stb_o) begin
                if (w == wait_n) begin
                    w = 0;
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected_mem_adr@%h", addr), mem_adr_o, 32'hFFFF_FFFF);
                    end else begin
                        check($sformatf("mem_adr@%h", addr), mem_adr_o, exp_q.pop_front());
                    end
                    mem_ack_i = 1'b1;
                    mem_dat_i = mem_word(mem_adr_o);
                    if (acks == inv_at) inv_i = 1'b1;
                    acks++;
                    nmem++;
                end else begin
                    w++;
                end
            end
        end
        if (!got) check($sformatf("ack_timeout@%h", addr), 32'd0, 32'd1);
        cpu_stb_i = 1'b0;
        mem_ack_i = 1'b0;
        inv_i     = 1'b0;
        @(negedge clk_i);
        check($sformatf("ack_single_pulse@%h", addr), 32'(cpu_ack_o), 32'd0);
    endtask

    // kind: 0 = hit, 1 = line fill, 2 = bypass read.
    task automatic run(input logic [31:0] addr, input int kind, input int wait_n,
                       input int inv_at, input logic [31:0] exp_dat);
        logic [31:0] dat;
        int lat;
        int nmem;
        int exp_lat;
        int exp_n;
        exp_q.delete();
        if (kind == 1) begin
            for (int i = 0; i < WORDS; i++) exp_q.push_back({addr[31:4], 4'(i * 4)});
            exp_n   = WORDS;
            exp_lat = 1 + WORDS * (wait_n + 1);
        end else if (kind == 2) begin
            exp_q.push_back({addr[31:2], 2'b00});
            exp_n   = 1;
            exp_lat = 1 + (wait_n + 1);
        end else begin
            exp_n   = 0;
            exp_lat = 1;
        end
        fetch(addr, wait_n, inv_at, dat, lat, nmem);
        check($sformatf("cpu_dat@%h", addr), dat, exp_dat);
        check($sformatf("latency@%h", addr), 32'(lat), 32'(exp_lat));
        check($sformatf("mem_reads@%h", addr), 32'(nmem), 32'(exp_n));
        check($sformatf("exp_q_drained@%h", addr), 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_i = 1'b1; cpu_stb_i = 1'b0; cpu_adr_i = '0; inv_i = 1'b0;
        mem_dat_i = '0; mem_ack_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_cpu_ack", 32'(cpu_ack_o), 32'd0);
        check("rst_mem_stb", 32'(mem_stb_o), 32'd0);
        check("rst_cpu_dat", cpu_dat_o, 32'd0);
        check("rst_mem_adr", mem_adr_o, 32'd0);
        check("rst_state", 32'(dbg_state_o), 32'd0);
        rst_i = 1'b0;

        // Cold fill of line 1, then hits in it.
        run(32'h0000_0014, 1, 0, -1, 32'h0000_00A1);
        run(32'h0000_0018, 0, 0, -1, 32'h0000_00A2);
        run(32'h0000_001C, 0, 1, -1, 32'h0000_00A3);
        // RAM alias of the same index/tag bypasses and leaves the line intact.
        run(32'h0800_0014, 2, 2, -1, 32'hD800_0014);
        run(32'h0000_0010, 0, 0, -1, 32'h0000_00A0);
        // Conflict on index 1 evicts, then the old address misses again.
        run(32'h0000_0054, 1, 0, -1, 32'hD000_0054);
        run(32'h0000_0058, 0, 0, -1, 32'hD000_0058);
        run(32'h0000_0014, 1, 1, -1, 32'h0000_00A1);
        // Bypass reads go to memory every time.
        run(32'h0800_0020, 2, 0, -1, 32'hD800_0020);
        run(32'h0800_0020, 2, 1, -1, 32'hD800_0020);

        // Invalidate mid-fill: word delivered, line left invalid.
        run(32'h0000_0000, 1, 0, 1, 32'hD000_0000);
        // Invalidate coincident with the final fill word: still invalid.
        run(32'h0000_0004, 1, 0, 3, 32'hD000_0004);
        run(32'h0000_0008, 1, 1, -1, 32'hD000_0008);
        run(32'h0000_000C, 0, 0, -1, 32'hD000_000C);
        // The invalidates also dropped line 1.
        run(32'h0000_0014, 1, 0, -1, 32'h0000_00A1);

        // Request withdrawn during RESP still gets its ack, no second one.
        @(negedge clk_i);
        cpu_stb_i = 1'b1;
        cpu_adr_i = 32'h0000_000C;
        @(posedge clk_i);
        #1 cpu_stb_i = 1'b0;
        @(negedge clk_i);
        check("resp_drop_ack", 32'(cpu_ack_o), 32'd1);
        check("resp_drop_dat", cpu_dat_o, 32'hD000_000C);
        @(negedge clk_i);
        check("resp_drop_ack_clear", 32'(cpu_ack_o), 32'd0);
        check("resp_drop_state", 32'(dbg_state_o), 32'd0);

        // Reset after the second fill word, with a memory ack in flight.
        @(negedge clk_i);
        cpu_stb_i = 1'b1;
        cpu_adr_i = 32'h0000_0038;
        @(negedge clk_i);
        check("rfill_stb0", 32'(mem_stb_o), 32'd1);
        check("rfill_adr0", mem_adr_o, 32'h0000_0030);
        mem_ack_i = 1'b1; mem_dat_i = mem_word(32'h0000_0030);
        @(negedge clk_i);
        check("rfill_adr1", mem_adr_o, 32'h0000_0034);
        mem_dat_i = mem_word(32'h0000_0034);
        @(negedge clk_i);
        check("rfill_adr2", mem_adr_o, 32'h0000_0038);
        mem_dat_i = mem_word(32'h0000_0038);
        rst_i = 1'b1;
        #1;
        check("rfill_stb_drop", 32'(mem_stb_o), 32'd0);
        check("rfill_state", 32'(dbg_state_o), 32'd0);
        check("rfill_mem_adr", mem_adr_o, 32'd0);
        @(negedge clk_i);
        check("rfill_no_ack", 32'(cpu_ack_o), 32'd0);
        mem_ack_i = 1'b0; cpu_stb_i = 1'b0; rst_i = 1'b0;
        @(negedge clk_i);
        check("rfill_idle_after", 32'(dbg_state_o), 32'd0);
        check("rfill_stb_after", 32'(mem_stb_o), 32'd0);
        run(32'h0000_0038, 1, 0, -1, 32'hD000_0038);
        // Reset cleared line 0 as well.
        run(32'h0000_000C, 1, 0, -1, 32'hD000_000C);
        run(32'h0000_003C, 0, 0, -1, 32'hD000_003C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_icache.md
WB_ICACHE -- requirements
Module: wb_icache

Interface
REQ-001 Parameter LINES, default 4, number of direct-mapped lines; power of two, 2..64.
REQ-002 Parameter WORDS, default 4, 32-bit words per line; power of two, 2..16.
REQ-003 clk_i  in  1  single clock; all state on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 cpu_stb_i  in  1  CPU instruction fetch request, held until cpu_ack_o.
REQ-006 cpu_adr_i  in  32  fetch byte address, word-aligned; bits [1:0] ignored.
REQ-007 cpu_dat_o  out  32  fetched instruction word, valid while cpu_ack_o=1.
REQ-008 cpu_ack_o  out  1  single-cycle completion pulse.
REQ-009 inv_i  in  1  invalidate all lines.
REQ-010 mem_stb_o  out  1  request to the QSPI memory controller, held until mem_ack_i.
REQ-011 mem_adr_o  out  32  word-aligned memory read address.
REQ-012 mem_dat_i  in  32  memory read data, sampled when mem_ack_i=1.
REQ-013 mem_ack_i  in  1  memory completion pulse.
REQ-014 Read-only block; no write-enable or byte-enable ports; mem side always full-word read.

Function
REQ-015 Address split: offset = adr[2+OB-1:2] (OB=log2 WORDS); index = adr[2+OB+IB-1:2+OB] (IB=log2 LINES); tag = adr[23:2+OB+IB].
REQ-016 Cacheable iff adr[27]=0 (ROM); adr[27]=1 (RAM) fetches bypass the cache.
REQ-017 FSM states: IDLE, FILL, BYPASS, RESP.
REQ-018 IDLE, cpu_stb_i=1, cacheable, valid[index]=1 and tag match (hit): register word into cpu_dat_o, go RESP.
REQ-019 IDLE, cacheable miss: latch request address, fill counter k=0, go FILL.
REQ-020 IDLE, non-cacheable: latch address, go BYPASS.
REQ-021 FILL: mem_stb_o=1, mem_adr_o = {adr[31:2+OB], k, 2'b00}; on mem_ack_i store mem_dat_i to word k, k+1; fill always starts at word 0.
REQ-022 FILL, ack of word WORDS-1: write tag, set valid[index], latch requested word into cpu_dat_o, go RESP.
REQ-023 BYPASS: mem_stb_o=1, mem_adr_o = latched address; on mem_ack_i latch mem_dat_i into cpu_dat_o, go RESP; cache contents unchanged.
REQ-024 RESP: cpu_ack_o=1 for exactly one cycle, go IDLE; cpu_ack_o is registered, never combinational from mem_ack_i.
REQ-025 Latency: hit = ack 2nd cycle after stb sampled in IDLE; miss = WORDS mem acks + 1 cycle; bypass = 1 mem ack + 1 cycle.
REQ-026 mem_stb_o deasserts in the cycle following the final mem_ack_i of a fill/bypass; between fill words it stays high.
REQ-027 cpu_stb_i low in RESP: ack still pulses (CPU contract forbids abort; no state corruption).
REQ-028 inv_i=1: clear all valid bits at next edge; in FILL, current fill completes and is acked but line is NOT marked valid.
REQ-029 inv_i and FILL completion in same cycle: invalidate wins; line left invalid.
REQ-030 Back-to-back: new request accepted in IDLE the cycle after RESP; never in RESP.
REQ-031 Index/tag of in-flight fill taken from latched address, never live cpu_adr_i.

Reset
REQ-032 rst_i=1 asynchronously: state IDLE, all valid=0, k=0, mem_stb_o=0, cpu_ack_o=0, cpu_dat_o=0, mem_adr_o=0.
REQ-033 Reset during FILL/BYPASS drops mem_stb_o immediately; a mem_ack_i arriving during or after reset is ignored.
REQ-034 Tag/data arrays need not reset.

Verification
REQ-035 Cold fetch 0x0000_0014 (LINES=4, WORDS=4), mem returns 0xA0..0xA3 -> mem_adr_o 0x10,0x14,0x18,0x1C; cpu_dat_o=0xA1; ack after 4th mem ack +1.
REQ-036 Then fetch 0x0000_0018 -> no mem_stb_o; cpu_dat_o=0xA2; ack 2 cycles after stb.
REQ-037 Fetch 0x0000_0054 (same index 1, new tag) -> refill 0x50..0x5C; subsequent 0x14 misses again.
REQ-038 Fetch 0x0800_0020 -> single mem read at 0x0800_0020, ack with its data; repeat fetch reads memory again.
REQ-039 inv_i pulse mid-fill of 0x00 -> ack delivered with correct word; re-fetch 0x00 triggers full refill.
REQ-040 rst_i asserted after 2nd fill word -> mem_stb_o=0 same cycle; post-reset fetch of same line refills from word 0.
